// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// alu_arbiter_pkg : op codes, FSM encoding and width defaults for alu_arbiter
// Revision 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

   localparam int C_DATA_W = 32;
   localparam int C_OP_W   = 4;

   localparam logic [3:0] C_OP_ADD = 4'b0000;
   localparam logic [3:0] C_OP_OR  = 4'b0001;
   localparam logic [3:0] C_OP_AND = 4'b0010;
   localparam logic [3:0] C_OP_SUB = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// alu_arbiter_alu : combinational ALU (ADD/OR/AND/SUB), flags unknown op codes
// Revision 1.0 - initial release
// ============================================================================
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_W = C_DATA_W,
   parameter int OP_W   = C_OP_W
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              err
);

   // Unknown op codes yield a zero result so the zero flag reads high with err
   always_comb begin
      result = '0;
      err    = 1'b0;
      case (op)
         C_OP_ADD: result = a + b;
         C_OP_OR:  result = a | b;
         C_OP_AND: result = a & b;
         C_OP_SUB: result = a - b;
         default:  err    = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin arbitration of two requesters onto one shared ALU
// Revision 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_W = C_DATA_W,
   parameter int OP_W   = C_OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic              busy
);

   state_t              r_state;
   logic                r_last;
   logic                r_gnt;
   logic [OP_W-1:0]     r_op;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [DATA_W-1:0]   r_result;
   logic                r_zero;
   logic                r_err;
   logic                r_rsp0_valid;
   logic                r_rsp1_valid;
   logic                r_busy;

   logic                w_gnt;
   logic                w_accept;
   logic                w_rsp_hs;
   logic [DATA_W-1:0]   w_alu_result;
   logic                w_alu_err;

   // Contention goes to whoever was not served last; otherwise the lone requester
   assign w_gnt      = (req0_valid && req1_valid) ? ~r_last : req1_valid;
   assign req0_ready = (r_state == ST_IDLE) && req0_valid && !w_gnt;
   assign req1_ready = (r_state == ST_IDLE) && req1_valid &&  w_gnt;
   assign w_accept   = req0_ready || req1_ready;
   assign w_rsp_hs   = (r_state == ST_RESP) && (r_gnt ? rsp1_ready : rsp0_ready);

   alu_arbiter_alu #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .op     (r_op),
      .a      (r_a),
      .b      (r_b),
      .result (w_alu_result),
      .err    (w_alu_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last       <= 1'b1;
         r_gnt        <= 1'b0;
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_result     <= '0;
         r_zero       <= 1'b1;
         r_err        <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_gnt   <= w_gnt;
                  r_op    <= w_gnt ? req1_op : req0_op;
                  r_a     <= w_gnt ? req1_a  : req0_a;
                  r_b     <= w_gnt ? req1_b  : req0_b;
                  r_busy  <= 1'b1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_result     <= w_alu_result;
               r_zero       <= ~|w_alu_result;
               r_err        <= w_alu_err;
               r_rsp0_valid <= ~r_gnt;
               r_rsp1_valid <=  r_gnt;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (w_rsp_hs) begin
                  r_last       <= r_gnt;
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_rsp0_valid <= 1'b0;
               r_rsp1_valid <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;
   assign rsp_err    = r_err;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed self-checking bench for alu_arbiter
// Revision 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_err, busy;

   int passed = 0;
   int total  = 0;

   alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 100000", $time);
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp1_valid, busy, rsp_zero, rsp_err} !== 5'b00010)
         $display("FAIL reset_flags: got %b required 00010", {rsp0_valid, rsp1_valid, busy, rsp_zero, rsp_err});
      else passed++;
      total++;
      if (rsp_result !== 32'h0) $display("FAIL reset_result: got %h required 00000000", rsp_result);
      else passed++;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++;
      if ({req1_ready, req0_ready} !== 2'b01)
         $display("FAIL reset_first_grant: got %b required 01", {req1_ready, req0_ready});
      else passed++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_add();
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd5; req0_b = 32'd7; rsp0_ready = 1'b1;
      #1;
      total++;
      if (req0_ready !== 1'b1) $display("FAIL add_req_ready: got %b required 1", req0_ready);
      else passed++;
      @(negedge clk);
      total++;
      if ({busy, rsp0_valid, req0_ready} !== 3'b100)
         $display("FAIL add_exec_state: got %b required 100", {busy, rsp0_valid, req0_ready});
      else passed++;
      // Scramble the inputs after acceptance; the in-flight result must not move
      req0_valid = 1'b0; req0_op = 4'b0110; req0_a = 32'hDEAD_BEEF; req0_b = 32'h1;
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_err} !== 4'b1000)
         $display("FAIL add_rsp_flags: got %b required 1000", {rsp0_valid, rsp1_valid, rsp_zero, rsp_err});
      else passed++;
      total++;
      if (rsp_result !== 32'd12) $display("FAIL add_result: got %h required 0000000c", rsp_result);
      else passed++;
      @(negedge clk);
      total++;
      if ({busy, rsp0_valid} !== 2'b00) $display("FAIL add_back_idle: got %b required 00", {busy, rsp0_valid});
      else passed++;
      rsp0_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_res;
      do_reset();
      req0_valid = 1'b1; req0_op = 4'b0110; req0_a = 32'd3;    req0_b = 32'd3;
      req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'hF0;   req1_b = 32'h0F;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_res = (k % 2 == 1) ? 32'hFF : 32'h0;
         #1;
         total++;
         if ({req1_ready, req0_ready} !== ((k % 2 == 1) ? 2'b10 : 2'b01))
            $display("FAIL rr_grant%0d: got %b required %b", k, {req1_ready, req0_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
         else passed++;
         @(negedge clk);
         @(negedge clk);
         total++;
         if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== ((k % 2 == 1) ? 4'b1000 : 4'b0100))
            $display("FAIL rr_rsp%0d: got %b required %b", k, {rsp1_valid, rsp0_valid, req1_ready, req0_ready},
                     (k % 2 == 1) ? 4'b1000 : 4'b0100);
         else passed++;
         total++;
         if ({rsp_result, rsp_zero} !== {exp_res, (k % 2 == 0)})
            $display("FAIL rr_result%0d: got %h/%b required %h/%b", k, rsp_result, rsp_zero, exp_res, (k % 2 == 0));
         else passed++;
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic test_add_wrap();
      @(negedge clk);
      req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; rsp1_ready = 1'b1;
      #1;
      total++;
      if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL wrap_grant: got %b required 10", {req1_ready, req0_ready});
      else passed++;
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({rsp1_valid, rsp_result, rsp_zero, rsp_err} !== {1'b1, 32'h0, 1'b1, 1'b0})
         $display("FAIL wrap_result: got v=%b r=%h z=%b e=%b required v=1 r=00000000 z=1 e=0",
                  rsp1_valid, rsp_result, rsp_zero, rsp_err);
      else passed++;
      @(negedge clk);
      rsp1_ready = 1'b0;
   endtask

   task automatic test_bad_op();
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 4'b1111; req0_a = 32'd5; req0_b = 32'd3; rsp0_ready = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp_result, rsp_zero, rsp_err} !== {1'b1, 32'h0, 1'b1, 1'b1})
         $display("FAIL badop_result: got v=%b r=%h z=%b e=%b required v=1 r=00000000 z=1 e=1",
                  rsp0_valid, rsp_result, rsp_zero, rsp_err);
      else passed++;
      @(negedge clk);
      total++;
      if ({busy, rsp0_valid} !== 2'b00) $display("FAIL badop_idle: got %b required 00", {busy, rsp0_valid});
      else passed++;
      rsp0_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'h1200; req1_b = 32'h0034;
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      @(negedge clk);
      req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, busy} !== 5'b10001 || rsp_result !== 32'h1234)
            $display("FAIL hold%0d: got flags=%b r=%h required flags=10001 r=00001234", i,
                     {rsp1_valid, rsp0_valid, req1_ready, req0_ready, busy}, rsp_result);
         else passed++;
         @(negedge clk);
      end
      rsp1_ready = 1'b1; req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, rsp1_valid} !== 2'b00) $display("FAIL hold_release: got %b required 00", {busy, rsp1_valid});
      else passed++;
      rsp1_ready = 1'b0; rsp0_ready = 1'b0;
   endtask

   task automatic test_reset_in_exec();
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'hFF; req0_b = 32'h0F; rsp0_ready = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if ({rsp0_valid, rsp1_valid, busy, rsp_zero} !== 4'b0001 || rsp_result !== 32'h0)
         $display("FAIL rst_exec_async: got flags=%b r=%h required flags=0001 r=00000000",
                  {rsp0_valid, rsp1_valid, busy, rsp_zero}, rsp_result);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000)
         $display("FAIL rst_exec_no_rsp: got %b required 000", {rsp0_valid, rsp1_valid, busy});
      else passed++;
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd10; req0_b = 32'd20;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({rsp0_valid, rsp_result, rsp_err} !== {1'b1, 32'd30, 1'b0})
         $display("FAIL rst_exec_next: got v=%b r=%h e=%b required v=1 r=0000001e e=0", rsp0_valid, rsp_result, rsp_err);
      else passed++;
      @(negedge clk);
      rsp0_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_add_wrap();
      test_bad_op();
      test_backpressure();
      test_reset_in_exec();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
